// File: rtl/mem_access_stage_if.sv
// Memory bus between the MEM stage and the data memory: a registered request
// that is held until a single-cycle ack. The data and byte-enable vectors use
// big-endian numbering, so bit 0 is the MSB and mem_be[0] covers bits [0:7].
interface mem_access_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [0:31] mem_addr;
    logic [0:31] mem_wdata;
    logic [0:3]  mem_be;
    logic [0:31] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline. Non-memory instructions retire to
// writeback one cycle later. LW/SW/LB/LBU/SB run one bus transaction each and
// stall upstream until the transaction completes. Misaligned word accesses and
// bus timeouts raise a single-cycle mem_err and do not reach writeback.
module mem_access_stage #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       valid_mem,
    input  logic [0:31]                insn,
    input  logic [0:31]                alu_out,
    input  logic [0:31]                store_data,
    output logic                       stall,
    mem_access_stage_if.master         bus,
    output logic                       wb_valid,
    output logic [0:31]                wb_data,
    output logic [0:31]                wb_insn,
    output logic                       mem_err
);

    localparam logic [0:5] OP_LW  = 6'b100011;
    localparam logic [0:5] OP_SW  = 6'b101011;
    localparam logic [0:5] OP_LB  = 6'b100000;
    localparam logic [0:5] OP_LBU = 6'b100100;
    localparam logic [0:5] OP_SB  = 6'b101000;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    // Operation details captured at accept, so completion never depends on
    // what upstream presents once the stall has been released.
    logic             op_load;
    logic             op_byte;
    logic             op_signed;
    logic [0:1]       op_off;
    logic [0:31]      op_alu;

    logic [0:5] opcode;
    logic [0:1] off;
    logic       is_lw, is_sw, is_lb, is_lbu, is_sb;
    logic       is_mem, is_word, is_byte, misaligned;
    logic       accept, abort;

    // Byte enables: all four lanes for word ops, one lane for byte ops.
    function automatic logic [0:3] byte_enable(input logic byte_op, input logic [0:1] lane);
        logic [0:3] be;
        if (byte_op) begin
            be       = 4'b0000;
            be[lane] = 1'b1;
        end else begin
            be = 4'b1111;
        end
        return be;
    endfunction

    // Store data: byte stores drive the byte onto every lane.
    function automatic logic [0:31] store_lanes(input logic byte_op, input logic [0:31] data);
        logic [0:31] wd;
        if (byte_op) begin
            wd = {4{data[24:31]}};
        end else begin
            wd = data;
        end
        return wd;
    endfunction

    // Load result: full word, or the addressed byte right-justified and
    // sign- or zero-extended.
    function automatic logic [0:31] load_extract(input logic [0:31] rdata, input logic byte_op,
                                                 input logic sext, input logic [0:1] lane);
        logic [0:7]  b;
        logic [0:31] res;
        b = rdata[{lane, 3'b000} +: 8];
        if (!byte_op) begin
            res = rdata;
        end else if (sext) begin
            res = {{24{b[0]}}, b};
        end else begin
            res = {24'h000000, b};
        end
        return res;
    endfunction

    // Decode the incoming instruction and derive the handshake terms.
    always_comb begin
        opcode     = insn[0:5];
        off        = alu_out[30:31];
        is_lw      = (opcode == OP_LW);
        is_sw      = (opcode == OP_SW);
        is_lb      = (opcode == OP_LB);
        is_lbu     = (opcode == OP_LBU);
        is_sb      = (opcode == OP_SB);
        is_word    = is_lw | is_sw;
        is_byte    = is_lb | is_lbu | is_sb;
        is_mem     = is_word | is_byte;
        misaligned = is_word & (off != 2'b00);
        accept     = (state == S_IDLE) & valid_mem & is_mem & ~misaligned;
        abort      = (state == S_WAIT) & ~bus.mem_ack & (wait_cnt == CNT_LAST);
        stall      = accept | ((state == S_WAIT) & ~bus.mem_ack & ~abort);
    end

    // Latch the details of an accepted memory op for use at completion.
    always_ff @(posedge clock) begin
        if (accept) begin
            op_load   <= is_lw | is_lb | is_lbu;
            op_byte   <= is_byte;
            op_signed <= is_lb;
            op_off    <= off;
            op_alu    <= alu_out;
        end
    end

    // Control FSM: bus request, writeback pulse and error pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            wait_cnt      <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
            wb_valid      <= 1'b0;
            wb_data       <= '0;
            wb_insn       <= '0;
            mem_err       <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            mem_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid_mem) begin
                        if (!is_mem) begin
                            wb_valid <= 1'b1;
                            wb_data  <= alu_out;
                            wb_insn  <= insn;
                        end else if (misaligned) begin
                            mem_err <= 1'b1;
                        end else begin
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= is_sw | is_sb;
                            bus.mem_addr  <= {alu_out[0:29], 2'b00};
                            bus.mem_be    <= byte_enable(is_byte, off);
                            bus.mem_wdata <= store_lanes(is_sb, store_data);
                            wb_insn       <= insn;
                            wait_cnt      <= '0;
                            state         <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        wb_valid    <= 1'b1;
                        wb_data     <= op_load ?
                                       load_extract(bus.mem_rdata, op_byte, op_signed, op_off) :
                                       op_alu;
                        state       <= S_IDLE;
                    end else if (abort) begin
                        bus.mem_req <= 1'b0;
                        mem_err     <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: a memory responder with programmable ack delay,
// a writeback/error scoreboard and a bus-request scoreboard.
module tb_mem_access_stage;

    localparam int MAXW = 12;
    localparam int CW   = 4;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_ALU = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b001101;

    logic        clock;
    logic        reset;
    logic        valid_mem;
    logic [31:0] insn;
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [31:0] wb_insn;
    logic        mem_err;

    mem_access_stage_if bus ();

    mem_access_stage #(.MAX_WAIT(MAXW), .CNT_W(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .valid_mem  (valid_mem),
        .insn       (insn),
        .alu_out    (alu_out),
        .store_data (store_data),
        .stall      (stall),
        .bus        (bus.master),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .wb_insn    (wb_insn),
        .mem_err    (mem_err)
    );

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        logic [31:0] insn;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          chk_wdata;
    } bus_exp_t;

    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    int          ack_delay  = 0;
    logic [31:0] rdata_cfg  = '0;
    bit          resp_en    = 1'b1;
    bit          manual_ack = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Memory responder: acks after ack_delay wait cycles and checks the request.
    initial begin
        int  wcnt;
        bit  auto_ack;
        bus_exp_t e;
        wcnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clock);
            auto_ack = 1'b0;
            if (bus.mem_req === 1'b1 && resp_en) begin
                if (wcnt == ack_delay) begin
                    auto_ack      = 1'b1;
                    wcnt          = 0;
                    bus.mem_rdata = rdata_cfg;
                    if (bus_q.size() == 0) begin
                        check_eq("bus_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = bus_q.pop_front();
                        check_eq("bus_we",   {31'd0, bus.mem_we}, {31'd0, e.we});
                        check_eq("bus_addr", bus.mem_addr, e.addr);
                        check_eq("bus_be",   {28'd0, bus.mem_be}, {28'd0, e.be});
                        if (e.chk_wdata) check_eq("bus_wdata", bus.mem_wdata, e.wdata);
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
            bus.mem_ack = auto_ack | manual_ack;
        end
    end

    // Writeback/error monitor: pops one expectation per output pulse.
    initial begin
        wb_exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (wb_valid === 1'b1 || mem_err === 1'b1) begin
                check_eq("pulse_excl", {31'd0, wb_valid & mem_err}, 32'd0);
                if (wb_q.size() == 0) begin
                    check_eq("out_unexpected", {30'd0, wb_valid, mem_err}, 32'd0);
                end else begin
                    e = wb_q.pop_front();
                    check_eq("out_kind", {31'd0, mem_err}, {31'd0, e.is_err});
                    if (!e.is_err) begin
                        check_eq("wb_data", wb_data, e.data);
                        check_eq("wb_insn", wb_insn, e.insn);
                    end
                end
            end
        end
    end

    // Issue one instruction (called at a negedge, returns at a negedge) and
    // push the expected bus request, output and stall length.
    task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] sd,
                         input int dly, input logic [31:0] rd, input bit do_ack);
        logic [5:0]  op;
        logic [1:0]  off;
        logic [7:0]  b;
        logic [31:0] ld;
        bit          mem, word, byt, load, sgn;
        int          exp_stall, n;
        op   = i[31:26];
        off  = a[1:0];
        word = (op == OP_LW) || (op == OP_SW);
        byt  = (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
        mem  = word || byt;
        load = (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
        sgn  = (op == OP_LB);
        b    = 8'((rd >> (8 * (3 - int'(off)))) & 32'hFF);
        if (!byt)     ld = rd;
        else if (sgn) ld = {{24{b[7]}}, b};
        else          ld = {24'd0, b};

        if (!mem) begin
            wb_q.push_back('{is_err: 1'b0, data: a, insn: i});
            exp_stall = 0;
        end else if (word && off != 2'b00) begin
            wb_q.push_back('{is_err: 1'b1, data: '0, insn: '0});
            exp_stall = 0;
        end else if (!do_ack) begin
            wb_q.push_back('{is_err: 1'b1, data: '0, insn: '0});
            exp_stall = MAXW;
        end else begin
            bus_q.push_back('{we: !load, addr: {a[31:2], 2'b00},
                              be: byt ? (4'b1000 >> off) : 4'b1111,
                              wdata: (op == OP_SB) ? {4{sd[7:0]}} : sd,
                              chk_wdata: !load});
            wb_q.push_back('{is_err: 1'b0, data: load ? ld : a, insn: i});
            exp_stall = 1 + dly;
        end

        ack_delay  = dly;
        rdata_cfg  = rd;
        resp_en    = do_ack;
        insn       = i;
        alu_out    = a;
        store_data = sd;
        valid_mem  = 1'b1;
        n = 0;
        #1;
        while (stall === 1'b1 && n < MAXW + 20) begin
            n++;
            @(negedge clock);
            #1;
        end
        check_eq("stall_cycles", n, exp_stall);
        @(negedge clock);
        valid_mem = 1'b0;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op);
        return {op, 26'h0A5_1234};
    endfunction

    initial begin
        logic [5:0] ops [7];
        logic [5:0] op;
        logic [31:0] a;
        ops = '{OP_ALU, OP_LW, OP_SW, OP_LB, OP_LBU, OP_SB, OP_ORI};

        reset      = 1'b1;
        valid_mem  = 1'b0;
        insn       = '0;
        alu_out    = '0;
        store_data = '0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_mem_req",  {31'd0, bus.mem_req}, 32'd0);
        check_eq("rst_mem_we",   {31'd0, bus.mem_we}, 32'd0);
        check_eq("rst_mem_be",   {28'd0, bus.mem_be}, 32'd0);
        check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
        check_eq("rst_wdata",    bus.mem_wdata, 32'd0);
        check_eq("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("rst_wb_data",  wb_data, 32'd0);
        check_eq("rst_wb_insn",  wb_insn, 32'd0);
        check_eq("rst_mem_err",  {31'd0, mem_err}, 32'd0);
        check_eq("rst_stall",    {31'd0, stall}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Directed cases.
        issue({OP_ALU, 20'h0, 6'b100001}, 32'h0000_0010, 32'h0, 0, 32'h0, 1'b1);
        issue(mk(OP_LW),  32'h0000_0104, 32'h5555_5555, 3, 32'hDEAD_BEEF, 1'b1);
        issue(mk(OP_LB),  32'h0000_0103, 32'h0, 1, 32'h1122_33F0, 1'b1);
        issue(mk(OP_LBU), 32'h0000_0103, 32'h0, 1, 32'h1122_33F0, 1'b1);
        issue(mk(OP_SB),  32'h0000_0201, 32'h0000_00AB, 0, 32'h0, 1'b1);
        issue(mk(OP_SW),  32'h0000_0102, 32'h1234_5678, 0, 32'h0, 1'b1);
        issue(mk(OP_LW),  32'h0000_0300, 32'h0, 0, 32'h0, 1'b0);
        check_eq("abort_req_low", {31'd0, bus.mem_req}, 32'd0);
        issue(mk(OP_SW),  32'h0000_0400, 32'h1234_5678, 2, 32'h0, 1'b1);
        issue(mk(OP_LB),  32'h0000_0500, 32'h0, 0, 32'h80FF_0102, 1'b1);
        issue(mk(OP_LBU), 32'h0000_0502, 32'h0, 4, 32'h80FF_9102, 1'b1);
        issue(mk(OP_ORI), 32'hFFFF_FFFF, 32'h0, 0, 32'h0, 1'b1);
        issue(mk(OP_LW),  32'h0000_0601, 32'h0, 0, 32'h0, 1'b1);

        // Reset in the middle of a wait, then a late ack.
        resp_en   = 1'b0;
        insn      = mk(OP_LW);
        alu_out   = 32'h0000_0700;
        valid_mem = 1'b1;
        repeat (3) @(negedge clock);
        reset     = 1'b1;
        valid_mem = 1'b0;
        @(posedge clock);
        #2;
        manual_ack = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("rst_wait_req",   {31'd0, bus.mem_req}, 32'd0);
        check_eq("rst_wait_stall", {31'd0, stall}, 32'd0);
        @(posedge clock);
        #2;
        manual_ack = 1'b0;
        check_eq("rst_late_ack_wb",  {31'd0, wb_valid}, 32'd0);
        check_eq("rst_late_ack_err", {31'd0, mem_err}, 32'd0);
        check_eq("rst_late_ack_req", {31'd0, bus.mem_req}, 32'd0);
        resp_en = 1'b1;
        @(negedge clock);

        // Random mix, issued back to back.
        for (int k = 0; k < 24; k++) begin
            op = ops[$urandom_range(0, 6)];
            a  = $urandom;
            if ((op == OP_LW || op == OP_SW) && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            issue(mk(op), a, $urandom, $urandom_range(0, 4), $urandom, 1'b1);
        end

        repeat (3) @(negedge clock);
        check_eq("wb_q_drained",  wb_q.size(), 32'd0);
        check_eq("bus_q_drained", bus_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
